// File: rtl/enigma_rotor_stage.sv
// One Enigma rotor: loadable forward/inverse wiring, ring setting, stepping
// position with turnover notch, and a 2-stage valid/ready substitution pipeline.
module enigma_rotor_stage #(
    parameter int ALPHA     = 26,
    parameter int W         = 5,
    parameter int NOTCH_RST = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [W-1:0] cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_set,
    input  logic [W-1:0] cfg_pos,
    input  logic [W-1:0] cfg_ring,
    input  logic [W-1:0] cfg_notch,
    input  logic         step_in,
    output logic         carry_out,
    output logic [W-1:0] pos,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_dir,
    output logic [W-1:0] out_data
);

    localparam logic [W:0] ALPHA_X = (W+1)'(ALPHA);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_X) s = s - ALPHA_X;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + ALPHA_X;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_reduce(input logic [W-1:0] v);
        logic [W:0] s;
        s = {1'b0, v};
        if (s >= ALPHA_X) s = s - ALPHA_X;
        return s[W-1:0];
    endfunction

    logic [W-1:0] fwd_q [ALPHA];
    logic [W-1:0] inv_q [ALPHA];

    logic [W-1:0] pos_q, pos_d, ring_q, ring_d, notch_q, notch_d;
    logic         carry_q, carry_d;

    logic         s1_valid_q, s1_dir_q, s1_byp_q;
    logic [W-1:0] s1_data_q, s1_off_q;
    logic         s1_byp_d;
    logic [W-1:0] s1_data_d, s1_off_d;

    logic         out_valid_q, out_dir_q;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] t_fwd, t_inv;
    logic         adv1, adv2, cfg_ok;

    assign adv2      = !out_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign cfg_ok    = cfg_we && ({1'b0, cfg_addr} < ALPHA_X) && ({1'b0, cfg_data} < ALPHA_X);

    assign carry_out = carry_q;
    assign pos       = pos_q;
    assign out_valid = out_valid_q;
    assign out_dir   = out_dir_q;
    assign out_data  = out_data_q;

    // cfg_set has priority over step_in and suppresses the carry
    always_comb begin
        pos_d   = pos_q;
        ring_d  = ring_q;
        notch_d = notch_q;
        carry_d = 1'b0;
        if (cfg_set) begin
            pos_d   = mod_reduce(cfg_pos);
            ring_d  = mod_reduce(cfg_ring);
            notch_d = mod_reduce(cfg_notch);
        end else if (step_in) begin
            pos_d   = mod_add(pos_q, W'(1));
            carry_d = (pos_q == notch_q);
        end
    end

    always_comb begin
        s1_off_d  = mod_sub(pos_q, ring_q);
        s1_byp_d  = ({1'b0, in_data} >= ALPHA_X);
        s1_data_d = s1_byp_d ? in_data : mod_add(in_data, s1_off_d);
    end

    always_comb begin
        t_fwd = '0;
        t_inv = '0;
        for (int unsigned k = 0; k < ALPHA; k++) begin
            if (s1_data_q == W'(k)) begin
                t_fwd = fwd_q[k];
                t_inv = inv_q[k];
            end
        end
        out_data_d = s1_byp_q ? s1_data_q : mod_sub(s1_dir_q ? t_inv : t_fwd, s1_off_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < ALPHA; k++) begin
                fwd_q[k] <= W'(k);
                inv_q[k] <= W'(k);
            end
        end else if (cfg_ok) begin
            for (int unsigned k = 0; k < ALPHA; k++) begin
                if (cfg_addr == W'(k)) fwd_q[k] <= cfg_data;
                if (cfg_data == W'(k)) inv_q[k] <= cfg_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q   <= '0;
            ring_q  <= '0;
            notch_q <= W'(NOTCH_RST);
            carry_q <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            ring_q  <= ring_d;
            notch_q <= notch_d;
            carry_q <= carry_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_dir_q    <= 1'b0;
            s1_byp_q    <= 1'b0;
            s1_data_q   <= '0;
            s1_off_q    <= '0;
            out_valid_q <= 1'b0;
            out_dir_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_dir_q  <= in_dir;
                    s1_byp_q  <= s1_byp_d;
                    s1_data_q <= s1_data_d;
                    s1_off_q  <= s1_off_d;
                end
            end
            if (adv2) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_dir_q  <= s1_dir_q;
                    out_data_q <= out_data_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_enigma_rotor_stage.sv
// Directed bench for enigma_rotor_stage: vector table against rotor I wiring
// plus hand sequences for stepping, backpressure, in-flight step and reset.
module tb_enigma_rotor_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we, cfg_set, step_in;
    logic [4:0] cfg_addr, cfg_data, cfg_pos, cfg_ring, cfg_notch;
    logic       carry_out;
    logic [4:0] pos;
    logic       in_valid, in_ready, in_dir;
    logic [4:0] in_data;
    logic       out_valid, out_ready, out_dir;
    logic [4:0] out_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    enigma_rotor_stage #(.ALPHA(26), .W(5), .NOTCH_RST(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_set(cfg_set), .cfg_pos(cfg_pos), .cfg_ring(cfg_ring), .cfg_notch(cfg_notch),
        .step_in(step_in), .carry_out(carry_out), .pos(pos),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_dir(out_dir), .out_data(out_data)
    );

    typedef struct {
        int pos;
        int ring;
        int dir;
        int data;
        int exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int p, input int r, input int n);
        cfg_set = 1'b1; cfg_pos = 5'(p); cfg_ring = 5'(r); cfg_notch = 5'(n);
        tick();
        cfg_set = 1'b0;
    endtask

    // Sends one character into an empty pipeline with out_ready high.
    task automatic send(input int d, input int x, output int dat, output int dir, output int lat);
        in_valid = 1'b1; in_dir = d[0]; in_data = 5'(x);
        #1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat <= 8) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        dat = int'(out_data);
        dir = int'(out_dir);
        tick();
    endtask

    int   rot1 [26] = '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14,
                        22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9};
    vec_t vecs [13];
    int   dat, dir, lat, accepted, got;
    int   rec [4];
    logic acc_now;

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 4};
        vecs[1]  = '{0, 0, 1, 4, 0};
        vecs[2]  = '{1, 0, 0, 0, 9};
        vecs[3]  = '{1, 0, 1, 9, 0};
        vecs[4]  = '{0, 1, 0, 0, 10};
        vecs[5]  = '{3, 0, 0, 5, 18};
        vecs[6]  = '{3, 0, 1, 18, 5};
        vecs[7]  = '{25, 0, 0, 1, 5};
        vecs[8]  = '{25, 0, 1, 5, 1};
        vecs[9]  = '{27, 0, 0, 0, 9};
        vecs[10] = '{4, 30, 0, 2, 12};
        vecs[11] = '{5, 0, 1, 27, 27};
        vecs[12] = '{5, 0, 0, 31, 31};

        rst = 1'b1; cfg_we = 1'b0; cfg_set = 1'b0; step_in = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_pos = '0; cfg_ring = '0; cfg_notch = '0;
        in_valid = 1'b0; in_dir = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("reset pos", int'(pos), 0);
        check("reset carry", int'(carry_out), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset in_ready", int'(in_ready), 1);
        send(0, 0, dat, dir, lat);
        check("identity fwd 0", dat, 0);
        check("identity latency", lat, 2);

        for (int k = 0; k < 26; k++) begin
            cfg_we = 1'b1; cfg_addr = 5'(k); cfg_data = 5'(rot1[k]);
            tick();
        end
        cfg_we = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_cfg(vecs[i].pos, vecs[i].ring, 16);
            send(vecs[i].dir, vecs[i].data, dat, dir, lat);
            check($sformatf("vec%0d data", i), dat, vecs[i].exp);
            check($sformatf("vec%0d dir", i), dir, vecs[i].dir);
            check($sformatf("vec%0d latency", i), lat, 2);
        end

        // Stepping, notch carry, wrap, cfg_set priority
        set_cfg(16, 0, 16);
        step_in = 1'b1; tick(); step_in = 1'b0;
        check("step pos 17", int'(pos), 17);
        check("carry on notch", int'(carry_out), 1);
        tick();
        check("carry one cycle", int'(carry_out), 0);
        set_cfg(25, 0, 16);
        step_in = 1'b1; tick(); step_in = 1'b0;
        check("wrap pos", int'(pos), 0);
        check("wrap no carry", int'(carry_out), 0);
        set_cfg(16, 0, 16);
        step_in = 1'b1; cfg_set = 1'b1; cfg_pos = 5'd7; cfg_ring = '0; cfg_notch = 5'd16;
        tick();
        step_in = 1'b0; cfg_set = 1'b0;
        check("cfg_set over step pos", int'(pos), 7);
        check("cfg_set over step carry", int'(carry_out), 0);

        // Backpressure: only two fit while out_ready is low
        set_cfg(0, 0, 16);
        out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_dir = 1'b0; in_data = 5'(accepted);
            #1;
            acc_now = in_ready;
            tick();
            if (acc_now) accepted++;
        end
        #1;
        check("bp accepted", accepted, 2);
        check("bp in_ready low", int'(in_ready), 0);
        check("bp out_valid held", int'(out_valid), 1);
        check("bp out_data held", int'(out_data), 4);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            #1;
            if (out_valid) begin
                rec[got] = int'(out_data);
                got++;
            end
            acc_now = in_valid && in_ready;
            tick();
            if (acc_now) in_valid = 1'b0;
        end
        check("bp count", got, 3);
        check("bp out0", rec[0], 4);
        check("bp out1", rec[1], 10);
        check("bp out2", rec[2], 12);
        check("bp no duplicate", int'(out_valid), 0);

        // Step in the same cycle as accept uses the pre-step position
        set_cfg(0, 0, 16);
        in_valid = 1'b1; in_dir = 1'b0; in_data = 5'd0; step_in = 1'b1;
        tick();
        step_in = 1'b0;
        check("flight pos", int'(pos), 1);
        tick();
        in_valid = 1'b0;
        check("flight out0", int'(out_valid) * 100 + int'(out_data), 104);
        tick();
        check("flight out1", int'(out_valid) * 100 + int'(out_data), 109);
        tick();

        // Reset with two characters in flight
        set_cfg(5, 0, 16);
        in_valid = 1'b1; in_data = 5'd0; tick();
        in_data = 5'd1; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst out_valid", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst flush", int'(out_valid), 0);
        check("rst pos", int'(pos), 0);
        send(0, 3, dat, dir, lat);
        check("rst identity fwd", dat, 3);
        send(1, 10, dat, dir, lat);
        check("rst identity rev", dat, 10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
